// File: rtl/frame_streamer_pkg.sv
// Shared command and state encodings for the SDRAM-to-pixel-FIFO frame streamer.
package frame_streamer_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    S_INIT_GAP = 2'd0,
    S_INIT_WR  = 2'd1,
    S_IDLE     = 2'd2,
    S_READ     = 2'd3
  } state_e;

  // Command presented to the SDRAM controller while in a given state.
  function automatic cmd_e cmd_of(input state_e s);
    case (s)
      S_INIT_WR: return CMD_WRITE;
      S_READ:    return CMD_READ;
      default:   return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/frame_streamer_addr_gen.sv
// Frame offset counter with wrap, run-time base latch, word address adder and frame-start flag.
module frame_addr_gen #(
  parameter int ADDR_W      = 22,
  parameter int FRAME_WORDS = 96000,
  parameter int OFF_W       = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              latch_base,
  input  logic              mark_start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] address,
  output logic              frame_start
);

  localparam logic [OFF_W-1:0] LAST = OFF_W'(FRAME_WORDS - 1);

  logic [ADDR_W-1:0] base_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset      <= '0;
      base_q      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= mark_start;
      if (latch_base) base_q <= frame_base;
      if (advance)    offset <= (offset == LAST) ? '0 : offset + OFF_W'(1);
    end
  end

  // Address wraps modulo 2^ADDR_W.
  assign address = base_q + ADDR_W'(offset);

endmodule

// File: rtl/frame_streamer.sv
// Frame streamer top: bursts SDRAM words into the pixel FIFO with hysteresis and double buffering.
// Optional init fill pattern enabled by defining FRAME_STREAMER_INIT_PATTERN_EN.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 32,
  parameter int USED_W      = 10,
  parameter int FIFO_DEPTH  = 1024,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 96000,
  parameter int LOW_WATER   = 256
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Enable,
  input  logic [ADDR_W-1:0] i_Frame_Base,
  input  logic              i_Data_Read_Valid,
  input  logic              i_Data_Write_Done,
  input  logic [USED_W-1:0] i_Pixel_In_Used,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [DATA_W-1:0] o_Data_Write,
  output logic              o_FIFO_Wr,
  output logic              o_First_Data_Ready,
  output logic              o_Frame_Start,
  output logic              o_Init_Done
);

  localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [31:0] LOW_TH  = 32'(LOW_WATER);
  localparam logic [31:0] HIGH_TH = 32'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(BURST_LEN - 1);

  generate
    if (FRAME_WORDS % BURST_LEN != 0) begin : g_bad_burst
      $error("FRAME_WORDS must be a multiple of BURST_LEN");
    end
  endgenerate

`ifdef FRAME_STREAMER_INIT_PATTERN_EN
  localparam state_e RESET_STATE   = S_INIT_GAP;
  localparam logic   INIT_DONE_RST = 1'b0;
`else
  localparam state_e RESET_STATE   = S_IDLE;
  localparam logic   INIT_DONE_RST = 1'b1;
`endif

  state_e            state, state_next;
  cmd_e              cmd_q;
  logic [CNT_W-1:0]  count, count_next;
  logic              filling;
  logic              advance, latch_req, read_start, first_set, init_set;
  logic [OFF_W-1:0]  offset;
  logic              offset_zero;
  logic [31:0]       used_v;
  logic              start_ok, room;

  assign offset_zero = (offset == '0);
  assign used_v      = 32'(i_Pixel_In_Used);
  assign room        = (used_v < HIGH_TH);
  assign start_ok    = i_Enable && o_Init_Done && ((used_v <= LOW_TH) || filling) && room;

`ifdef FRAME_STREAMER_INIT_PATTERN_EN
  logic offset_last;
  assign offset_last  = (offset == OFF_W'(FRAME_WORDS - 1));
  assign o_Data_Write = {(DATA_W/8){8'(offset)}};
`else
  assign o_Data_Write = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    advance    = 1'b0;
    latch_req  = 1'b0;
    read_start = 1'b0;
    first_set  = 1'b0;
    init_set   = 1'b0;
    case (state)
`ifdef FRAME_STREAMER_INIT_PATTERN_EN
      S_INIT_GAP: begin
        latch_req  = 1'b1;
        count_next = CNT_START;
        state_next = S_INIT_WR;
      end
      S_INIT_WR: begin
        if (i_Data_Write_Done) begin
          advance = 1'b1;
          if (count == '0) begin
            if (offset_last) begin
              init_set   = 1'b1;
              state_next = S_IDLE;
            end else begin
              state_next = S_INIT_GAP;
            end
          end else begin
            count_next = count - CNT_W'(1);
          end
        end
      end
`endif
      S_IDLE: begin
        if (start_ok) begin
          read_start = 1'b1;
          latch_req  = 1'b1;
          count_next = CNT_START;
          state_next = S_READ;
        end
      end
      S_READ: begin
        // A started burst always runs to completion; enable and thresholds are only sampled in S_IDLE.
        if (i_Data_Read_Valid) begin
          advance = 1'b1;
          if (count == '0) begin
            first_set  = 1'b1;
            state_next = S_IDLE;
          end else begin
            count_next = count - CNT_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state              <= RESET_STATE;
      cmd_q              <= CMD_IDLE;
      count              <= '0;
      filling            <= 1'b0;
      o_First_Data_Ready <= 1'b0;
      o_Init_Done        <= INIT_DONE_RST;
    end else begin
      state <= state_next;
      cmd_q <= cmd_of(state_next);
      count <= count_next;
      if (read_start) filling <= 1'b1;
      else if (!room) filling <= 1'b0;
      if (first_set) o_First_Data_Ready <= 1'b1;
      if (init_set)  o_Init_Done        <= 1'b1;
    end
  end

  assign o_Command = cmd_q;
  assign o_FIFO_Wr = (cmd_q == CMD_READ) && i_Data_Read_Valid;

  frame_addr_gen #(
    .ADDR_W      (ADDR_W),
    .FRAME_WORDS (FRAME_WORDS),
    .OFF_W       (OFF_W)
  ) u_addr_gen (
    .clk         (i_Clk),
    .rst_n       (i_Rst_n),
    .advance     (advance),
    .latch_base  (latch_req && offset_zero),
    .mark_start  (read_start && offset_zero),
    .frame_base  (i_Frame_Base),
    .offset      (offset),
    .address     (o_Data_Address),
    .frame_start (o_Frame_Start)
  );

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: stimulus pushes expected words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_frame_streamer;
  import frame_streamer_pkg::*;

  localparam int ADDR_W = 22, DATA_W = 32, USED_W = 10;
  localparam int FIFO_DEPTH = 1024, BURST_LEN = 8, FRAME_WORDS = 64, LOW_WATER = 256;
`ifdef FRAME_STREAMER_INIT_PATTERN_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, enable, rd_valid, wr_done;
  logic [ADDR_W-1:0] frame_base;
  logic [USED_W-1:0] used;
  logic [1:0]        command;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_wr, first_ready, frame_start, init_done;

  always #5 clk = ~clk;

  frame_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USED_W(USED_W), .FIFO_DEPTH(FIFO_DEPTH),
    .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .LOW_WATER(LOW_WATER)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_Frame_Base(frame_base),
    .i_Data_Read_Valid(rd_valid), .i_Data_Write_Done(wr_done), .i_Pixel_In_Used(used),
    .o_Command(command), .o_Data_Address(address), .o_Data_Write(wr_data),
    .o_FIFO_Wr(fifo_wr), .o_First_Data_Ready(first_ready), .o_Frame_Start(frame_start),
    .o_Init_Done(init_done)
  );

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int                model_off   = 0;
  logic [ADDR_W-1:0] model_base  = '0;
  logic              model_first = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every FIFO write or accepted init write must match the oldest expected word.
  always @(negedge clk) begin
    logic rd_ev, wr_ev;
    exp_t e;
    rd_ev = (fifo_wr === 1'b1);
    wr_ev = (command === CMD_WRITE) && (wr_done === 1'b1);
    if (rd_ev || wr_ev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got rd=%0b wr=%0b addr=0x%0h, expected no event", rd_ev, wr_ev, address);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {63'd0, wr_ev}, {63'd0, e.is_write});
        check("event_addr", 64'(address), 64'(e.addr));
        if (e.is_write) check("init_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read(input string tag);
    int k = 0;
    while (command !== CMD_READ && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_read_issued"}, 64'(command), 64'(CMD_READ));
  endtask

  // One read burst; drop_at/gap_at select the valid index where enable drops or a valid gap is inserted.
  task automatic run_burst(input string tag, input int drop_at, input int gap_at);
    exp_t e;
    wait_read(tag);
    if (model_off == 0) model_base = frame_base;
    check({tag, "_frame_start"}, {63'd0, frame_start}, {63'd0, model_off == 0});
    check({tag, "_first_ready"}, {63'd0, first_ready}, {63'd0, model_first});
    for (int i = 0; i < BURST_LEN; i++) begin
      if (i == drop_at) enable = 1'b0;
      if (i == gap_at) begin
        rd_valid = 1'b0;
        tick();
        check({tag, "_gap_hold"}, 64'(command), 64'(CMD_READ));
      end
      e.is_write = 1'b0;
      e.addr     = model_base + ADDR_W'(model_off);
      e.data     = '0;
      exp_q.push_back(e);
      rd_valid = 1'b1;
      tick();
      if (i == 0) check({tag, "_pulse_end"}, {63'd0, frame_start}, 64'd0);
      model_off = (model_off + 1) % FRAME_WORDS;
    end
    rd_valid    = 1'b0;
    model_first = 1'b1;
  endtask

  // Stray valids are held high while no burst may start.
  task automatic expect_idle(input string tag, input int n);
    rd_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_idle"}, 64'(command), 64'(CMD_IDLE));
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [7:0] b;
    rst_n = 1'b0; enable = 1'b0; frame_base = '0; rd_valid = 1'b0; wr_done = 1'b0; used = 10'd1020;

    // Reset held three cycles, stray valids ignored.
    tick(); rd_valid = 1'b1; tick(); tick();
    check("rst_command",     64'(command), 64'(CMD_IDLE));
    check("rst_address",     64'(address), 64'd0);
    check("rst_data",        64'(wr_data), 64'd0);
    check("rst_fifo_wr",     {63'd0, fifo_wr}, 64'd0);
    check("rst_first_ready", {63'd0, first_ready}, 64'd0);
    check("rst_frame_start", {63'd0, frame_start}, 64'd0);
    check("rst_init_done",   {63'd0, init_done}, {63'd0, ~INIT_EN});
    rd_valid = 1'b0;

`ifdef FRAME_STREAMER_INIT_PATTERN_EN
    // Init fill: base 0x100, write-done held high, pattern = offset byte replicated.
    for (int k = 0; k < FRAME_WORDS; k++) begin
      b = 8'(k);
      e.is_write = 1'b1;
      e.addr     = 22'h100 + ADDR_W'(k);
      e.data     = {4{b}};
      exp_q.push_back(e);
    end
    frame_base = 22'h100; wr_done = 1'b1; rst_n = 1'b1;
    for (int k = 0; k < 300 && init_done !== 1'b1; k++) tick();
    check("init_done_set", {63'd0, init_done}, 64'd1);
    wr_done = 1'b0; frame_base = '0;
    tick();
    check("init_addr_wrapped", 64'(address), 64'h100);
    check("init_cmd_idle", 64'(command), 64'(CMD_IDLE));
`else
    rst_n = 1'b1;
    tick();
    check("init_done_tied", {63'd0, init_done}, 64'd1);
    check("post_rst_idle", 64'(command), 64'(CMD_IDLE));
`endif

    // Threshold hysteresis.
    enable = 1'b1; used = 10'd256;
    run_burst("b0_off0", -1, 3);
    used = 10'd600;
    run_burst("b1_off8", -1, -1);
    used = 10'd1016;
    expect_idle("full", 5);
    used = 10'd300;
    expect_idle("above_low", 5);
    used = 10'd256;
    run_burst("b2_off16", -1, -1);

    // Base change mid-frame applies at the next offset-0 burst.
    used = 10'd600; frame_base = 22'h2000;
    run_burst("b3_off24", -1, -1);
    run_burst("b4_off32", -1, -1);
    run_burst("b5_off40", -1, -1);
    run_burst("b6_off48", -1, -1);
    run_burst("b7_off56", -1, -1);
    run_burst("b8_newframe", -1, -1);
    check("new_base_addr", 64'(address), 64'h2008);

    // Enable dropped after three valids: burst completes, then stays idle.
    run_burst("b9_drop_en", 3, -1);
    expect_idle("disabled", 4);
    enable = 1'b1;
    run_burst("b10_resume", -1, -1);
    check("resume_addr", 64'(address), 64'h2018);

    // Reset mid-read.
    wait_read("b11_reset");
    for (int i = 0; i < 4; i++) begin
      e.is_write = 1'b0;
      e.addr     = model_base + ADDR_W'(model_off);
      e.data     = '0;
      exp_q.push_back(e);
      rd_valid = 1'b1;
      if (i == 3) rst_n = 1'b0;
      tick();
      model_off = (model_off + 1) % FRAME_WORDS;
    end
    check("midrst_command",     64'(command), 64'(CMD_IDLE));
    check("midrst_address",     64'(address), 64'd0);
    check("midrst_first_ready", {63'd0, first_ready}, 64'd0);
    check("midrst_fifo_wr",     {63'd0, fifo_wr}, 64'd0);
    tick();
    check("midrst_fifo_wr_hold", {63'd0, fifo_wr}, 64'd0);
    rd_valid = 1'b0;
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
